bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Inverse of the team's combinational BCD-to-binary decoder. Default sizes are the same shared DECLEN/BINLEN, so the two blocks round-trip.
- Used where a binary count must drive decimal digit displays and a multi-cycle latency is acceptable in exchange for small area.

Parameters:
- DECLEN, 9, number of BCD output digits.
- BINLEN, 30, width of the binary input (bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only when busy=0.
- BIN  input  BINLEN  binary operand; captured on the accepting edge only.
- BCD  output  DECLEN*4  result, packed as digit i at BCD[i*4+:4] (digit 0 is least significant); registered.
- ovf  output  1  result is at least 10**DECLEN; registered, updated together with BCD.
- busy  output  1  conversion in progress.
- done  output  1  single-cycle pulse: BCD/ovf were updated this cycle.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high. It is sampled on the clk edge and overrides everything, including mid-conversion.
  - Reset values: BCD=0, ovf=0, busy=0, done=0, FSM=IDLE, all internal registers 0.
  - A conversion aborted by reset produces no done pulse, and BCD/ovf read 0.
- FSM states: IDLE, CONV.
- IDLE:
  - busy=0.
  - On an edge with start=1:
    - shift register ← BIN.
    - working digits ← 0.
    - sticky overflow ← 0.
    - bit counter ← BINLEN-1.
    - go to CONV.
  - start=0: stay in IDLE.
- CONV (busy=1), on each edge:
  - Adjust: every working digit ≥5 gets +3 (4-bit result, no inter-digit carry).
  - Shift: the {digits, shift register} concatenation shifts left by 1. The MSB of the shift register enters digit 0 bit 0.
  - The bit shifted out of the top digit's MSB is ORed into the sticky overflow.
  - Counter decrements.
  - When the counter is 0 at the edge:
    - BCD ← final shifted digits.
    - ovf ← sticky OR final carry-out.
    - done=1 for the next cycle.
    - go to IDLE.
- Latency:
  - start accepted at edge E0. Then busy=1 from after E0 through the edge E0+BINLEN.
  - done=1 and busy=0 in the cycle following edge E0+BINLEN, which is exactly BINLEN cycles after acceptance.
- BCD and ovf hold their last result during a conversion. They change only on the completion edge or on reset.
- start while busy=1 is ignored: no queuing, and BIN is not re-sampled.
- start during the done cycle is accepted, since the FSM is in IDLE. This gives back-to-back throughput of one result per BINLEN cycles.
- Arithmetic:
  - Result = BIN mod 10**DECLEN, in BCD.
  - ovf=1 if and only if BIN ≥ 10**DECLEN.
  - Every output digit is 0..9.
- Edge-case parameters:
  - BINLEN=1 is legal: 1-cycle latency.
  - DECLEN large enough that overflow is impossible makes ovf constant 0 by construction; no special casing.

Decomposition:
- Shared header bcd_size.vh holds the DECLEN/BINLEN defaults, so the encoder and decoder agree.
- No typedef package is needed.
- One natural sub-module: bcd_add3, the combinational per-digit cell (in 4 bits, out = in≥5 ? in+3 : in), instantiated DECLEN times in a generate loop.
- FSM, counter and shift register stay in the top-level block.

Test Plan:
- Reset, then start with BIN=0 → done pulses exactly 30 cycles after acceptance; BCD=0x000000000, ovf=0, busy high for exactly 30 cycles.
- BIN=999999999 → BCD=0x999999999, ovf=0. BIN=123456789 → BCD=0x123456789, ovf=0.
- BIN=1000000000 → BCD=0x000000000, ovf=1. BIN=1073741823 (2^30-1) → BCD=0x073741823, ovf=1.
- Start BIN=42, then at cycle 10 pulse start with BIN=7 → second start is ignored; result is 0x000000042 at cycle 30. Then start BIN=7 in the done cycle → accepted; 0x000000007 after a further 30 cycles; previous BCD held in between.
- Start BIN=555, assert rst at cycle 15 → cycle after: busy=0, BCD=0, ovf=0, and no done pulse ever appears. Then BIN=555 → 0x000000555.
- Random BIN (10k samples) fed through bin2bcd_seq then the combinational decoder → decoded value equals BIN mod 10^9, and the decoder's ovf is 0.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared sizing defaults and FSM encoding for the BCD encoder/decoder pair.
// The encoder and decoder both take their default digit and bit counts from here.
package bin2bcd_seq_pkg;

    localparam int unsigned DecLenDefault = 9;
    localparam int unsigned BinLenDefault = 30;

    typedef enum logic {
        StIdle,
        StConv
    } state_e;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit cell: adds 3 to a BCD digit that is 5 or more, so the
// following left shift carries it correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// The result and overflow flag are registered and change only on completion or reset.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned DECLEN = DecLenDefault,
    parameter int unsigned BINLEN = BinLenDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BINLEN-1:0]     BIN,
    output logic [DECLEN*4-1:0]   BCD,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CntW = (BINLEN > 1) ? $clog2(BINLEN) : 1;
    localparam int unsigned DigW = DECLEN * 4;

    state_e              state_q, state_d;
    logic [BINLEN-1:0]   shift_q, shift_d;
    logic [DigW-1:0]     digits_q, digits_d;
    logic                sticky_q, sticky_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DigW-1:0]     bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [DigW-1:0]     adjusted;
    logic [DigW-1:0]     shifted;
    logic                carry_out;

    for (genvar g = 0; g < DECLEN; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (digits_q[g*4 +: 4]),
            .digit_o (adjusted[g*4 +: 4])
        );
    end

    // The shift register's MSB enters digit 0; the top digit's MSB falls out as carry.
    assign shifted   = {adjusted[DigW-2:0], shift_q[BINLEN-1]};
    assign carry_out = adjusted[DigW-1];

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        digits_d = digits_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d  = BIN;
                    digits_d = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CntW'(BINLEN - 1);
                    state_d  = StConv;
                end
            end
            StConv: begin
                shift_d  = shift_q << 1;
                digits_d = shifted;
                sticky_d = sticky_q | carry_out;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    bcd_d   = shifted;
                    ovf_d   = sticky_q | carry_out;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            digits_q <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            digits_q <= digits_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign BCD  = bcd_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == StConv);
    assign done = done_q;

endmodule
